// File: rtl/updown_mod_counter_if.sv
// Control/status bundle for updown_mod_counter: count controls in, count/co/ovf out.
// The master drives the controls and the slave (the counter) drives the status.
interface updown_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             clkEn;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] din;
    logic             clr_ovf;
    logic [WIDTH-1:0] count;
    logic             co;
    logic             ovf;

    modport master (
        output en, clkEn, up, load, din, clr_ovf,
        input  count, co, ovf
    );

    modport slave (
        input  en, clkEn, up, load, din, clr_ovf,
        output count, co, ovf
    );
endinterface

// File: rtl/updown_mod_counter.sv
// Up/down modulo-MODULUS counter with clamped parallel load and a sticky overflow flag.
// Define COUNTER_SAT_EN to hold at the terminal value instead of wrapping.
module updown_mod_counter #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 10,
    parameter int RESET_VAL = 0
) (
    input logic                 clk,
    input logic                 rst,
    updown_mod_counter_if.slave bus
);
    // Load comparison is one bit wider so MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_X   = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_V   = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] terminal;
    logic             adv;
    logic             at_term;
    logic             wrap;
    logic             ovf_q;

    always_comb begin
        terminal = bus.up ? MAX_VAL : '0;
        adv      = bus.clkEn & bus.en & ~bus.load;
        at_term  = (count_q == terminal);
        wrap     = rst & adv & at_term;
    end

    always_comb begin
        count_nxt = count_q;
        if (bus.load) begin
            count_nxt = ({1'b0, bus.din} >= MOD_X) ? MAX_VAL : bus.din;
        end else if (bus.en) begin
            if (at_term) begin
`ifdef COUNTER_SAT_EN
                count_nxt = count_q;
`else
                count_nxt = bus.up ? '0 : MAX_VAL;
`endif
            end else if (bus.up) begin
                count_nxt = count_q + WIDTH'(1);
            end else begin
                count_nxt = count_q - WIDTH'(1);
            end
        end
    end

    // A wrap on the same edge as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= RST_V;
            ovf_q   <= 1'b0;
        end else if (bus.clkEn) begin
            count_q <= count_nxt;
            if (wrap)
                ovf_q <= 1'b1;
            else if (bus.clr_ovf)
                ovf_q <= 1'b0;
        end
    end

    assign bus.count = count_q;
    assign bus.co    = wrap;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter (WIDTH=4, MODULUS=10, RESET_VAL=0).
// Define COUNTER_SAT_EN at compile time to exercise saturating mode.
module tb_updown_mod_counter;
  localparam int W = 4;

  logic clk;
  logic rst;
  int   assert_cnt = 0;
  int   fail_cnt   = 0;
  logic [W-1:0] exp_q[$];

  updown_mod_counter_if #(.WIDTH(W)) bus ();

  updown_mod_counter #(.WIDTH(W), .MODULUS(10), .RESET_VAL(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    assert_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic ce, input logic e, input logic u, input logic ld,
                       input logic [W-1:0] d, input logic clr);
    bus.clkEn   = ce;
    bus.en      = e;
    bus.up      = u;
    bus.load    = ld;
    bus.din     = d;
    bus.clr_ovf = clr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 1, 0, '0, 0);
    #10;
    check("reset_count", 16'(bus.count), 16'd0);
    check("reset_ovf", 16'(bus.ovf), 16'd0);
    check("reset_co", 16'(bus.co), 16'd0);
    rst = 1'b1;

    // async reset mid-count at 7
    drive(1, 1, 1, 0, '0, 0);
    repeat (7) tick();
    check("pre_reset_count", 16'(bus.count), 16'd7);
    rst = 1'b0;
    #1;
    check("async_reset_count", 16'(bus.count), 16'd0);
    check("async_reset_ovf", 16'(bus.ovf), 16'd0);
    check("async_reset_co", 16'(bus.co), 16'd0);
    drive(0, 0, 1, 0, '0, 0);
    rst = 1'b1;
    tick();
    check("post_reset_hold", 16'(bus.count), 16'd0);

`ifndef COUNTER_SAT_EN
    // count up 12 edges: 1..9,0,1,2
    begin
      int seq[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
      logic [W-1:0] prev;
      foreach (seq[i]) exp_q.push_back(W'(seq[i]));
      prev = '0;
      drive(1, 1, 1, 0, '0, 0);
      for (int i = 0; i < 12; i++) begin
        logic [W-1:0] e;
        check("up_co", 16'(bus.co), (prev == 4'd9) ? 16'd1 : 16'd0);
        tick();
        e = exp_q.pop_front();
        check("up_count", 16'(bus.count), 16'(e));
        check("up_ovf", 16'(bus.ovf), (i >= 9) ? 16'd1 : 16'd0);
        prev = e;
      end
    end

    // clear ovf, then count down through 0
    drive(1, 0, 1, 0, '0, 1);
    tick();
    check("clr_ovf", 16'(bus.ovf), 16'd0);
    check("clr_hold_count", 16'(bus.count), 16'd2);
    drive(1, 1, 0, 0, '0, 0);
    check("dn_co_at2", 16'(bus.co), 16'd0);
    repeat (2) tick();
    check("dn_count0", 16'(bus.count), 16'd0);
    check("dn_co_at0", 16'(bus.co), 16'd1);
    tick();
    check("dn_wrap_count", 16'(bus.count), 16'd9);
    check("dn_wrap_ovf", 16'(bus.ovf), 16'd1);
    repeat (4) tick();
    check("dn_count5", 16'(bus.count), 16'd5);
    drive(1, 0, 0, 0, '0, 1);
    tick();
    check("clr_ovf_at5", 16'(bus.ovf), 16'd0);
    check("clr_count5", 16'(bus.count), 16'd5);
`else
    // bring count to 5 without wrapping
    drive(1, 1, 1, 0, '0, 0);
    repeat (5) tick();
    check("sat_count5", 16'(bus.count), 16'd5);
`endif

    // load with clamp
    drive(1, 1, 1, 1, 4'd13, 0);
    check("load_co_at5", 16'(bus.co), 16'd0);
    tick();
    check("load13_clamp", 16'(bus.count), 16'd9);
    drive(1, 1, 1, 1, 4'd13, 0);
    check("load_co_at9", 16'(bus.co), 16'd0);
    tick();
    check("load13_again", 16'(bus.count), 16'd9);
    check("load_no_ovf", 16'(bus.ovf), 16'd0);
    drive(0, 0, 1, 1, 4'd4, 0);
    check("clken0_co", 16'(bus.co), 16'd0);
    tick();
    check("clken0_hold", 16'(bus.count), 16'd9);
    drive(0, 1, 1, 0, '0, 0);
    check("clken0_en_co", 16'(bus.co), 16'd0);
    drive(1, 0, 1, 1, 4'd4, 0);
    tick();
    check("load4", 16'(bus.count), 16'd4);
    drive(1, 0, 1, 1, 4'd10, 0);
    tick();
    check("load10_clamp", 16'(bus.count), 16'd9);
    drive(1, 0, 0, 0, '0, 0);
    check("hold_en0_co", 16'(bus.co), 16'd0);
    tick();
    check("hold_en0", 16'(bus.count), 16'd9);

`ifndef COUNTER_SAT_EN
    // wrap and clear on the same edge: set wins
    drive(1, 1, 1, 0, '0, 1);
    check("setwins_co", 16'(bus.co), 16'd1);
    tick();
    check("setwins_ovf", 16'(bus.ovf), 16'd1);
    check("setwins_count", 16'(bus.count), 16'd0);
`else
    // saturate at 9 for three edges, then step down
    drive(1, 1, 1, 0, '0, 0);
    for (int i = 0; i < 3; i++) begin
      check("sat_co", 16'(bus.co), 16'd1);
      tick();
      check("sat_count", 16'(bus.count), 16'd9);
      check("sat_ovf", 16'(bus.ovf), 16'd1);
    end
    drive(1, 1, 0, 0, '0, 0);
    check("sat_dn_co", 16'(bus.co), 16'd0);
    tick();
    check("sat_dn_count", 16'(bus.count), 16'd8);
    drive(1, 0, 0, 1, 4'd0, 1);
    tick();
    check("sat_load0", 16'(bus.count), 16'd0);
    check("sat_clr_ovf", 16'(bus.ovf), 16'd0);
    drive(1, 1, 0, 0, '0, 0);
    check("sat_lo_co", 16'(bus.co), 16'd1);
    tick();
    check("sat_lo_count", 16'(bus.count), 16'd0);
    check("sat_lo_ovf", 16'(bus.ovf), 16'd1);
`endif

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end
endmodule
